// File: rtl/serial_alu_engine.sv
// rtl/serial_alu_engine.sv - bit-serial ALU engine with valid/ready request and result handshakes
//
// Purpose: accepts one WIDTH-bit operation per request, runs it LSB-first through a
// 1-bit full-adder/logic slice (one bit per clock) and presents the assembled result
// with zero/carry/overflow flags.
//
// Optional feature macro: SERIAL_ALU_FLAGS_EN
//   defined     - zero_o/carry_o/overflow_o computed and registered on DONE entry
//   not defined - flag logic omitted, flag outputs tied to 0
//
// Ports:
//   clk_i            clock, all state updates on rising edge
//   reset_i          synchronous active-high reset
//   start_valid_i    operation request valid
//   start_ready_o    engine idle and able to accept a request
//   op_i[2:0]        000 MOV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT a, 111 NOR
//   a_i, b_i         operands, sampled only at the accepting edge
//   result_o         assembled result register (meaningful while result_valid_o)
//   result_valid_o   result and flags valid
//   result_ready_i   consumer accepts result
//   zero_o           result == 0
//   carry_o          final carry out (ADD/SUB/MOV only; SUB carry=1 means no borrow)
//   overflow_o       signed overflow (carry into MSB xor carry out of MSB)

module serial_alu_engine #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_valid_i,
   output logic             start_ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic             zero_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   localparam logic [2:0] OP_MOV = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_NOT = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic [WIDTH-1:0] result_q, result_d;

   // 1-bit slice signals
   logic             arith;
   logic             a_bit;
   logic             b_bit;
   logic             sum_bit;
   logic             cout_bit;
   logic             slice_bit;
   logic [WIDTH-1:0] res_shift;

   always_comb begin
      arith    = (op_q == OP_MOV) || (op_q == OP_ADD) || (op_q == OP_SUB);
      a_bit    = a_sh_q[0];
      // MOV is a+0 and SUB is a+~b+1 (the +1 comes from the carry FF preset at accept)
      case (op_q)
         OP_SUB:  b_bit = ~b_sh_q[0];
         OP_MOV:  b_bit = 1'b0;
         default: b_bit = b_sh_q[0];
      endcase
      sum_bit  = a_bit ^ b_bit ^ cy_q;
      cout_bit = (a_bit & b_bit) | (a_bit & cy_q) | (b_bit & cy_q);
      case (op_q)
         OP_AND:  slice_bit = a_bit & b_bit;
         OP_OR:   slice_bit = a_bit | b_bit;
         OP_XOR:  slice_bit = a_bit ^ b_bit;
         OP_NOT:  slice_bit = ~a_bit;
         OP_MOV, OP_ADD, OP_SUB: slice_bit = sum_bit;
         default: slice_bit = ~(a_bit | b_bit);
      endcase
      // new bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB
      res_shift = {slice_bit, result_q[WIDTH-1:1]};
   end

`ifdef SERIAL_ALU_FLAGS_EN
   logic zero_q, zero_d;
   logic carry_q, carry_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      cy_d     = cy_q;
      result_d = result_q;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_valid_i) begin
               a_sh_d  = a_i;
               b_sh_d  = b_i;
               op_d    = op_i;
               cnt_d   = '0;
               cy_d    = (op_i == OP_SUB);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            result_d = res_shift;
            cy_d     = arith & cout_bit;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = S_DONE;
`ifdef SERIAL_ALU_FLAGS_EN
               zero_d  = (res_shift == '0);
               carry_d = arith & cout_bit;
               // cy_q is the carry into the MSB at this point
               ovf_d   = arith & (cy_q ^ cout_bit);
`endif
            end
         end
         S_DONE: begin
            if (result_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         cy_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         cy_q     <= cy_d;
         result_q <= result_d;
      end
   end

`ifdef SERIAL_ALU_FLAGS_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign zero_o     = zero_q;
   assign carry_o    = carry_q;
   assign overflow_o = ovf_q;
`else
   assign zero_o     = 1'b0;
   assign carry_o    = 1'b0;
   assign overflow_o = 1'b0;
`endif

   assign start_ready_o  = (state_q == S_IDLE);
   assign result_valid_o = (state_q == S_DONE);
   assign result_o       = result_q;

endmodule
